pipe_mux_n: RTL and testbench
=============================

// Module: pipe_mux_n
// PURPOSE
//  Parametrised N:1 datapath select stage with a registered output and valid/ready flow control.
//  Generalises the combinational 2/3-way operand mux to NUM_IN inputs and a binary select.
//  Illegal selects produce a defined zero result plus an error flag; they never produce X.
//  A 2-entry skid buffer lets the stage sit between pipeline stages without a combinational ready path.
// PARAMETERS
//  WIDTH   16               data width per input
//  NUM_IN  3                number of data inputs (>=2)
//  SEL_W   $clog2(NUM_IN)   select width (derived, do not override)
//  CNT_W   8                width of the saturating illegal-select counter
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous active-low reset
//  flush        in   1             synchronous clear of buffered entries
//  in_valid     in   1             upstream offers sel/in_data this cycle
//  in_ready     out  1             stage can accept; registered, =!FULL
//  sel          in   SEL_W         binary select; index 0 picks in_data[WIDTH-1:0]
//  in_data      in   NUM_IN*WIDTH  flattened inputs; input k at [k*WIDTH +: WIDTH]
//  out_valid    out  1             out_data/out_err valid
//  out_ready    in   1             downstream accepts this cycle
//  out_data     out  WIDTH         selected data of head entry
//  out_err      out  1             head entry came from an illegal sel (>=NUM_IN)
//  err_cnt      out  CNT_W         count of accepted illegal selects, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state EMPTY, out_valid=0, in_ready=1, out_data=0, out_err=0, err_cnt=0.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  On push: entry = {err, data}; data = in_data[sel*WIDTH +: WIDTH] if sel<NUM_IN else 0, err = (sel>=NUM_IN).
//  Latency: a push at cycle t is visible on out_* at t+1 when the buffer was EMPTY or popped at t.
//  States (count of held entries):
//   EMPTY: push -> ONE.  No push -> EMPTY.
//   ONE:   push&pop -> ONE (new entry becomes head); push only -> FULL; pop only -> EMPTY.
//   FULL:  in_ready=0, so no push; pop -> ONE (skid entry moves to head); else hold.
//  out_valid = (state!=EMPTY); out_data/out_err always reflect head entry; held stable while out_valid & !out_ready.
//  in_ready depends only on registered state; there is no combinational path from out_ready.
//  Order preserved: entries leave in acceptance order; no entry dropped or duplicated.
//  err_cnt increments by 1 on every push with err=1; it saturates at 2^CNT_W-1 and is cleared only by reset.
//  flush=1: next state EMPTY, out_valid=0; a push in the same cycle is discarded and does not count in err_cnt.
//  When out_valid=0, out_data and out_err read 0.
//  sel/in_data are don't-care when in_valid=0 or in_ready=0, and are never sampled then.
//  Reset asserted mid-transfer discards all entries immediately; there is no partial output.
// TESTING
//  T1 reset: rst_n=0 mid-stream with FULL buffer -> out_valid=0, in_ready=1, err_cnt=0 asynchronously.
//  T2 select sweep (NUM_IN=3, WIDTH=16): in_data={16'hCCCC,16'hBBBB,16'hAAAA}, sel=0,1,2 with out_ready=1 -> out_data AAAA,BBBB,CCCC one cycle later, out_err=0.
//  T3 illegal sel=3 -> out_data=0000, out_err=1, err_cnt 0->1; with CNT_W=2, 5 illegal pushes -> err_cnt=3 (saturated).
//  T4 backpressure: out_ready=0 and push 2 items (11,22) -> in_ready=0 after the 2nd; out_data holds 11. Release -> 11 then 22, no loss.
//  T5 simultaneous push+pop in ONE for 10 cycles (values 1..10) -> one output per cycle, in order, state stays ONE.
//  T6 flush with in_valid=1 and sel=3 in FULL -> next cycle out_valid=0, in_ready=1, err_cnt unchanged.

Source files
------------

// File: rtl/pipe_mux_n.sv
// N:1 select stage with registered output and a 2-entry skid buffer.
// Illegal selects yield zero data plus an error flag and bump a saturating counter.
module pipe_mux_n #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic [CNT_W-1:0]        err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_head;
  logic [WIDTH:0]   r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_err;
  logic [WIDTH:0]   w_entry;
  logic             w_push;
  logic             w_pop;

  // Explicit compare loop keeps out-of-range selects at zero, never X.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_err   = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));
  assign w_entry = {w_err, w_sel_data};
  assign w_push  = in_valid & r_in_ready;
  assign w_pop   = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_err_cnt   <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_head      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push && w_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state     <= ONE;
            r_head      <= w_entry;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_entry;
          end else if (w_push) begin
            r_state    <= FULL;
            r_skid     <= w_entry;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state     <= EMPTY;
            r_head      <= '0;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state    <= ONE;
            r_head     <= r_skid;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_head      <= '0;
          r_skid      <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_head[WIDTH-1:0];
  assign out_err   = r_head[WIDTH];
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed bench for pipe_mux_n (NUM_IN=3, WIDTH=16, CNT_W=2).
// Expected values are hand-computed constants.
module tb_pipe_mux_n;

  localparam int WIDTH  = 16;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic [CNT_W-1:0]        err_cnt;

  int n_chk;
  int n_pass;

  pipe_mux_n #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel = '0; in_data = '0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // T2 select sweep
    in_data = {16'hCCCC, 16'hBBBB, 16'hAAAA};
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 2'd0; tick();
    check("t2_valid0", 32'(out_valid), 32'd1);
    check("t2_sel0", 32'(out_data), 32'hAAAA);
    check("t2_err0", 32'(out_err), 32'd0);
    sel = 2'd1; tick();
    check("t2_sel1", 32'(out_data), 32'hBBBB);
    sel = 2'd2; tick();
    check("t2_sel2", 32'(out_data), 32'hCCCC);
    check("t2_err2", 32'(out_err), 32'd0);

    // T3 illegal select and saturation
    sel = 2'd3; tick();
    check("t3_data", 32'(out_data), 32'h0);
    check("t3_err", 32'(out_err), 32'd1);
    check("t3_cnt1", 32'(err_cnt), 32'd1);
    tick();
    check("t3_cnt2", 32'(err_cnt), 32'd2);
    tick(); tick(); tick();
    check("t3_sat", 32'(err_cnt), 32'd3);
    in_valid = 1'b0; tick();
    check("t3_empty_v", 32'(out_valid), 32'd0);
    check("t3_empty_d", 32'(out_data), 32'h0);
    check("t3_empty_e", 32'(out_err), 32'd0);

    // T4 backpressure
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data = 48'h0011; tick();
    check("t4_rdy1", 32'(in_ready), 32'd1);
    check("t4_head1", 32'(out_data), 32'h11);
    in_data = 48'h0022; tick();
    check("t4_full", 32'(in_ready), 32'd0);
    check("t4_hold", 32'(out_data), 32'h11);
    in_data = 48'h0033; tick();
    check("t4_hold2", 32'(out_data), 32'h11);
    check("t4_nopush", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check("t4_second", 32'(out_data), 32'h22);
    check("t4_v2", 32'(out_valid), 32'd1);
    check("t4_rdy2", 32'(in_ready), 32'd1);
    tick();
    check("t4_drain", 32'(out_valid), 32'd0);

    // T1 async reset with buffer FULL
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    in_data = 48'h0044; tick();
    in_data = 48'h0055; tick();
    in_valid = 1'b0;
    check("t1_pre_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_cnt", 32'(err_cnt), 32'd0);
    check("t1_data", 32'(out_data), 32'h0);
    #3 rst_n = 1'b1;
    tick();

    // T5 streaming push+pop in ONE
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0;
    for (int i = 1; i <= 10; i++) begin
      in_data = 48'(i);
      tick();
      check("t5_data", 32'(out_data), 32'(i));
      check("t5_rdy", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; tick();
    check("t5_end", 32'(out_valid), 32'd0);

    // T6 flush
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 2'd3; tick();
    check("t6_cnt1", 32'(err_cnt), 32'd1);
    sel = 2'd0; in_data = 48'h0005; tick();
    check("t6_full", 32'(in_ready), 32'd0);
    flush = 1'b1; sel = 2'd3; tick();
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_cnt", 32'(err_cnt), 32'd1);
    tick();
    check("t6_empty_push", 32'(out_valid), 32'd0);
    check("t6_empty_cnt", 32'(err_cnt), 32'd1);
    flush = 1'b0; in_valid = 1'b0; tick();
    check("t6_out", 32'(out_data), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
